// File: rtl/rx_sync_ctrl.sv
// Receive-side word-sync controller for the 8b/10b decoder output stream.
// Runs a comma-based LOSS/ACQ/SYNC/SYNC_ERR machine, requests bit slips while
// unsynced, forwards symbols received while synced and counts code errors.
module rx_sync_ctrl #(
  parameter int unsigned COMMA_LOCK   = 3,
  parameter int unsigned MAX_ERR      = 4,
  parameter int unsigned GOOD_RUN     = 4,
  parameter int unsigned SLIP_HOLDOFF = 2,
  parameter int unsigned ERRCNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sym_valid,
  input  logic [7:0]          sym_data,
  input  logic                sym_k,
  input  logic                sym_invalid,
  input  logic                cnt_clr,
  output logic                slip_req,
  output logic                sync_ok,
  output logic                rx_valid,
  output logic [7:0]          rx_data,
  output logic                rx_k,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int unsigned CcntW = (COMMA_LOCK > 1) ? $clog2(COMMA_LOCK + 1) : 1;
  localparam int unsigned EcntW = (MAX_ERR > 1) ? $clog2(MAX_ERR + 1) : 1;
  localparam int unsigned GcntW = (GOOD_RUN > 1) ? $clog2(GOOD_RUN + 1) : 1;
  localparam int unsigned HoldW = (SLIP_HOLDOFF > 0) ? $clog2(SLIP_HOLDOFF + 1) : 1;

  localparam logic [CcntW-1:0] CommaLockC = CcntW'(COMMA_LOCK);
  localparam logic [EcntW-1:0] MaxErrC    = EcntW'(MAX_ERR);
  localparam logic [GcntW-1:0] GoodRunC   = GcntW'(GOOD_RUN);
  localparam logic [HoldW-1:0] HoldoffC   = HoldW'(SLIP_HOLDOFF);

  typedef enum logic [1:0] {
    StLoss    = 2'd0,
    StAcq     = 2'd1,
    StSync    = 2'd2,
    StSyncErr = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CcntW-1:0]    ccnt_q, ccnt_d;
  logic [EcntW-1:0]    ecnt_q, ecnt_d;
  logic [GcntW-1:0]    gcnt_q, gcnt_d;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic                slip_q, slip_d;
  logic                rx_valid_q, rx_valid_d;
  logic [7:0]          rx_data_q;
  logic                rx_k_q;
  logic [ERRCNT_W-1:0] err_q;

  logic comma, bad, good, next_synced;

  assign comma = !sym_invalid && sym_k && (sym_data == 8'hBC);
  assign bad   = sym_invalid;
  assign good  = !sym_invalid;

  // Next-state, counter and slip decode; evaluated once per valid symbol.
  always_comb begin
    state_d = state_q;
    ccnt_d  = ccnt_q;
    ecnt_d  = ecnt_q;
    gcnt_d  = gcnt_q;
    hold_d  = hold_q;
    slip_d  = 1'b0;
    if (sym_valid) begin
      unique case (state_q)
        StLoss: begin
          if (hold_q != '0) begin
            // Deserializer is still settling after the last slip.
            hold_d = hold_q - 1'b1;
          end else if (comma) begin
            if (COMMA_LOCK <= 1) begin
              state_d = StSync;
              ccnt_d  = '0;
            end else begin
              state_d = StAcq;
              ccnt_d  = CcntW'(1);
            end
          end else if (bad && !slip_q) begin
            // slip_q guard keeps pulses apart even with a zero holdoff.
            slip_d = 1'b1;
            hold_d = HoldoffC;
          end
        end
        StAcq: begin
          if (bad) begin
            state_d = StLoss;
            ccnt_d  = '0;
          end else if (comma) begin
            if (ccnt_q == CommaLockC - 1'b1) begin
              state_d = StSync;
              ccnt_d  = '0;
            end else begin
              ccnt_d = ccnt_q + 1'b1;
            end
          end
        end
        StSync: begin
          if (bad) begin
            if (MAX_ERR <= 1) begin
              state_d = StLoss;
              ecnt_d  = '0;
            end else begin
              state_d = StSyncErr;
              ecnt_d  = EcntW'(1);
            end
            gcnt_d = '0;
          end
        end
        StSyncErr: begin
          if (bad) begin
            gcnt_d = '0;
            if (ecnt_q == MaxErrC - 1'b1) begin
              state_d = StLoss;
              ecnt_d  = '0;
            end else begin
              ecnt_d = ecnt_q + 1'b1;
            end
          end else if (gcnt_q == GoodRunC - 1'b1) begin
            // A full good run retires one outstanding error.
            gcnt_d = '0;
            ecnt_d = ecnt_q - 1'b1;
            if (ecnt_q == EcntW'(1)) begin
              state_d = StSync;
            end
          end else begin
            gcnt_d = gcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StLoss;
        end
      endcase
    end
  end

  // Forward only good symbols whose post-edge state is synced.
  always_comb begin
    next_synced = (state_d == StSync) || (state_d == StSyncErr);
    rx_valid_d  = sym_valid && good && next_synced;
  end

  // FSM state, counters and slip pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoss;
      ccnt_q  <= '0;
      ecnt_q  <= '0;
      gcnt_q  <= '0;
      hold_q  <= '0;
      slip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ccnt_q  <= ccnt_d;
      ecnt_q  <= ecnt_d;
      gcnt_q  <= gcnt_d;
      hold_q  <= hold_d;
      slip_q  <= slip_d;
    end
  end

  // One-cycle forwarding register; data/K hold across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_k_q     <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid_d;
      if (sym_valid) begin
        rx_data_q <= sym_data;
        rx_k_q    <= sym_k;
      end
    end
  end

  // Saturating code-error counter; clear wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else if (cnt_clr) begin
      err_q <= '0;
    end else if (sym_valid && bad && !(&err_q)) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign slip_req  = slip_q;
  assign sync_ok   = (state_q == StSync) || (state_q == StSyncErr);
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign rx_k      = rx_k_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Self-checking bench for rx_sync_ctrl: forwarded symbols go through a
// scoreboard queue; state-visible outputs are checked inline per scenario.
module tb_rx_sync_ctrl;

  localparam logic [7:0] K285 = 8'hBC;
  localparam logic [7:0] D215 = 8'hB5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sym_valid = 1'b0;
  logic [7:0]  sym_data = 8'h00;
  logic        sym_k = 1'b0;
  logic        sym_invalid = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        slip_req, sync_ok, rx_valid, rx_k;
  logic [7:0]  rx_data;
  logic [15:0] err_count;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_err = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  mon_e;

  rx_sync_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .sym_valid  (sym_valid),
    .sym_data   (sym_data),
    .sym_k      (sym_k),
    .sym_invalid(sym_invalid),
    .cnt_clr    (cnt_clr),
    .slip_req   (slip_req),
    .sync_ok    (sync_ok),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_k       (rx_k),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every forwarded symbol must match the queue head.
  always @(posedge clk) begin
    #2;
    if (rx_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rx_unexpected got=%h required=none", {rx_k, rx_data});
      end else begin
        mon_e = exp_q.pop_front();
        if ({rx_k, rx_data} !== mon_e) begin
          n_bad++;
          $display("FAIL rx_symbol got=%h required=%h", {rx_k, rx_data}, mon_e);
        end
      end
    end
  end

  // One symbol (or idle) per cycle; fwd marks symbols expected on rx.
  task automatic send(input logic v, input logic [7:0] d, input logic k, input logic inv,
                      input logic fwd, input logic clr = 1'b0);
    @(negedge clk);
    sym_valid   = v;
    sym_data    = d;
    sym_k       = k;
    sym_invalid = inv;
    cnt_clr     = clr;
    if (fwd) exp_q.push_back({k, d});
    if (clr) exp_err = 0;
    else if (v && inv && exp_err != 65535) exp_err++;
    @(posedge clk);
    #1;
    sym_valid   = 1'b0;
    sym_invalid = 1'b0;
    cnt_clr     = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_err = 0;
    exp_q.delete();
  endtask

  task automatic do_lock();
    apply_reset();
    send(1'b1, K285, 1'b1, 1'b0, 1'b0);
    send(1'b1, K285, 1'b1, 1'b0, 1'b0);
    send(1'b1, K285, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (slip_req !== 1'b0) begin n_bad++; $display("FAIL rst_slip got=%b required=0", slip_req); end
    n_cmp++; if (sync_ok !== 1'b0) begin n_bad++; $display("FAIL rst_sync got=%b required=0", sync_ok); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rxv got=%b required=0", rx_valid); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL rst_rxd got=%h required=00", rx_data); end
    n_cmp++; if (rx_k !== 1'b0) begin n_bad++; $display("FAIL rst_rxk got=%b required=0", rx_k); end
    n_cmp++; if (err_count !== 16'h0) begin n_bad++; $display("FAIL rst_err got=%h required=0", err_count); end
  endtask

  task automatic test_lock();
    logic [7:0] d[6] = '{K285, D215, K285, D215, K285, D215};
    logic       k[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       s[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      send(1'b1, d[i], k[i], 1'b0, s[i]);
      n_cmp++;
      if (sync_ok !== s[i]) begin
        n_bad++; $display("FAIL lock_sync[%0d] got=%b required=%b", i, sync_ok, s[i]);
      end
    end
    send(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL lock_pending got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_slip();
    logic e;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
      e = (i == 0 || i == 3);
      n_cmp++;
      if (slip_req !== e) begin
        n_bad++; $display("FAIL slip[%0d] got=%b required=%b", i, slip_req, e);
      end
    end
    send(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (slip_req !== 1'b0) begin n_bad++; $display("FAIL slip_idle got=%b required=0", slip_req); end
    n_cmp++; if (err_count !== 16'd4) begin n_bad++; $display("FAIL slip_err got=%0d required=4", err_count); end
  endtask

  task automatic test_recovery();
    do_lock();
    send(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (sync_ok !== 1'b1) begin n_bad++; $display("FAIL rec_bad got=%b required=1", sync_ok); end
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (sync_ok !== 1'b1) begin n_bad++; $display("FAIL rec_good[%0d] got=%b required=1", i, sync_ok); end
    end
    // Back in SYNC the error level restarts at 1, so three bads keep sync.
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (sync_ok !== 1'b1) begin n_bad++; $display("FAIL rec_after[%0d] got=%b required=1", i, sync_ok); end
    end
    send(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rec_pending got=%0d required=0", exp_q.size()); end
    n_cmp++; if (err_count !== 16'(exp_err)) begin n_bad++; $display("FAIL rec_err got=%0d required=%0d", err_count, exp_err); end
  endtask

  task automatic test_loss();
    logic inv[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic s[5]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_lock();
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 8'h4A, 1'b0, inv[i], !inv[i]);
      n_cmp++;
      if (sync_ok !== s[i]) begin n_bad++; $display("FAIL loss_sync[%0d] got=%b required=%b", i, sync_ok, s[i]); end
    end
    send(1'b1, 8'h4A, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (slip_req !== 1'b1) begin n_bad++; $display("FAIL loss_slip got=%b required=1", slip_req); end
    send(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL loss_pending got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_gaps();
    logic       v[11] = '{1, 0, 0, 1, 1, 0, 1, 0, 1, 0, 1};
    logic [7:0] d[11] = '{K285, K285, K285, D215, K285, K285, D215, K285, K285, K285, D215};
    logic       k[11] = '{1, 1, 1, 0, 1, 1, 0, 1, 1, 1, 0};
    logic       s[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      send(v[i], d[i], k[i], 1'b0, v[i] & s[i]);
      n_cmp++;
      if (sync_ok !== s[i]) begin n_bad++; $display("FAIL gap_sync[%0d] got=%b required=%b", i, sync_ok, s[i]); end
    end
    send(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL gap_pending got=%0d required=0", exp_q.size()); end
    n_cmp++; if (rx_data !== D215) begin n_bad++; $display("FAIL gap_hold got=%h required=%h", rx_data, D215); end
  endtask

  task automatic test_counter();
    apply_reset();
    send(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (err_count !== 16'(exp_err)) begin n_bad++; $display("FAIL cnt_inc got=%0d required=%0d", err_count, exp_err); end
    send(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (err_count !== 16'h0) begin n_bad++; $display("FAIL cnt_clr got=%0d required=0", err_count); end
    @(negedge clk);
    force dut.err_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.err_q;
    exp_err = 65535;
    #1;
    n_cmp++; if (err_count !== 16'hFFFF) begin n_bad++; $display("FAIL cnt_force got=%h required=ffff", err_count); end
    send(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (err_count !== 16'hFFFF) begin n_bad++; $display("FAIL cnt_sat got=%h required=ffff", err_count); end
    send(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (err_count !== 16'h0) begin n_bad++; $display("FAIL cnt_clr2 got=%h required=0", err_count); end
  endtask

  task automatic test_reset_mid_acq();
    apply_reset();
    send(1'b1, K285, 1'b1, 1'b0, 1'b0);
    send(1'b1, K285, 1'b1, 1'b0, 1'b0);
    // Reset coincident with a comma must still win.
    @(negedge clk);
    rst = 1'b1; sym_valid = 1'b1; sym_data = K285; sym_k = 1'b1; sym_invalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0; sym_valid = 1'b0;
    n_cmp++; if (sync_ok !== 1'b0) begin n_bad++; $display("FAIL mid_sync got=%b required=0", sync_ok); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rxv got=%b required=0", rx_valid); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL mid_rxd got=%h required=00", rx_data); end
    n_cmp++; if (rx_k !== 1'b0) begin n_bad++; $display("FAIL mid_rxk got=%b required=0", rx_k); end
    n_cmp++; if (slip_req !== 1'b0) begin n_bad++; $display("FAIL mid_slip got=%b required=0", slip_req); end
    n_cmp++; if (err_count !== 16'h0) begin n_bad++; $display("FAIL mid_err got=%h required=0", err_count); end
    for (int i = 0; i < 3; i++) begin
      send(1'b1, K285, 1'b1, 1'b0, i == 2);
      n_cmp++;
      if (sync_ok !== (i == 2)) begin n_bad++; $display("FAIL mid_relock[%0d] got=%b required=%b", i, sync_ok, i == 2); end
    end
    send(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL mid_pending got=%0d required=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_slip();
    test_recovery();
    test_loss();
    test_gaps();
    test_counter();
    test_reset_mid_acq();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
